// File: rtl/encode_8b10b_multilane.sv
// encode_8b10b_multilane
//   N-lane 8b/10b encoder (IEEE 802.3 Cl.36), all 256 D codes plus the 12 valid
//   K codes. Each lane keeps its own running disparity. Valid/ready handshake on
//   both sides with a single registered output stage (latency 1 clk).
//
//   Parameters:
//     NUM_LANES  number of independent byte lanes per transfer
//     RD_INIT    lane RD after reset (0 = RD-, 1 = RD+)
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     in_data    lane i byte = in_data[8i+7:8i] (HGFEDCBA, A = bit 0)
//     in_k       per-lane control flag (1 = Kx.y)
//     in_valid   input transfer offered
//     in_ready   encoder can accept this cycle
//     out_code   lane i code = out_code[10i+9:10i] (abcdei fghj, a = bit 9)
//     out_valid  out_code holds an unconsumed code group set
//     out_ready  downstream consumes out_code this cycle
//     rd_out     per-lane RD after the code group now in out_code (1 = RD+)
//     k_err      per-lane invalid-K flag (only with ENCODE_K_CHECK_EN)
//   Build option:
//     ENCODE_K_CHECK_EN  adds k_err; invalid K bytes are replaced by K28.5.
//                        Without it, invalid K bytes are encoded as D codes.

module encode_8b10b_multilane #(
  parameter int unsigned NUM_LANES = 1,
  parameter bit          RD_INIT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*NUM_LANES-1:0]  in_data,
  input  logic [NUM_LANES-1:0]    in_k,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [10*NUM_LANES-1:0] out_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_LANES-1:0]    rd_out
`ifdef ENCODE_K_CHECK_EN
  ,
  output logic [NUM_LANES-1:0]    k_err
`endif
);

  // 5b/6b RD- column, abcdei with a as MSB
  function automatic logic [5:0] six_neg(input logic [4:0] x);
    logic [5:0] s;
    case (x)
      5'd0:  s = 6'b100111;  5'd1:  s = 6'b011101;  5'd2:  s = 6'b101101;
      5'd3:  s = 6'b110001;  5'd4:  s = 6'b110101;  5'd5:  s = 6'b101001;
      5'd6:  s = 6'b011001;  5'd7:  s = 6'b111000;  5'd8:  s = 6'b111001;
      5'd9:  s = 6'b100101;  5'd10: s = 6'b010101;  5'd11: s = 6'b110100;
      5'd12: s = 6'b001101;  5'd13: s = 6'b101100;  5'd14: s = 6'b011100;
      5'd15: s = 6'b010111;  5'd16: s = 6'b011011;  5'd17: s = 6'b100011;
      5'd18: s = 6'b010011;  5'd19: s = 6'b110010;  5'd20: s = 6'b001011;
      5'd21: s = 6'b101010;  5'd22: s = 6'b011010;  5'd23: s = 6'b111010;
      5'd24: s = 6'b110011;  5'd25: s = 6'b100110;  5'd26: s = 6'b010110;
      5'd27: s = 6'b110110;  5'd28: s = 6'b001110;  5'd29: s = 6'b101110;
      5'd30: s = 6'b011110;  default: s = 6'b101011;
    endcase
    return s;
  endfunction

  // 3b/4b data column used when RD6 is negative (D.x.7 is the P7 form)
  function automatic logic [3:0] four_neg(input logic [2:0] y);
    logic [3:0] f;
    case (y)
      3'd0: f = 4'b1011;  3'd1: f = 4'b1001;  3'd2: f = 4'b0101;  3'd3: f = 4'b1100;
      3'd4: f = 4'b1101;  3'd5: f = 4'b1010;  3'd6: f = 4'b0110;  default: f = 4'b1110;
    endcase
    return f;
  endfunction

  // K28.y 4b group following the RD- 6b group 001111 (i.e. with RD6 positive)
  function automatic logic [3:0] k28_four(input logic [2:0] y);
    logic [3:0] f;
    case (y)
      3'd0: f = 4'b0100;  3'd1: f = 4'b1001;  3'd2: f = 4'b0101;  3'd3: f = 4'b0011;
      3'd4: f = 4'b0010;  3'd5: f = 4'b1010;  3'd6: f = 4'b0110;  default: f = 4'b1000;
    endcase
    return f;
  endfunction

`ifdef ENCODE_K_CHECK_EN
  function automatic logic k_valid(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                 (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction
`endif

  // Returns {new_rd, abcdei, fghj}. K bytes outside the valid set fall through to
  // the D path because neither is_k28 nor is_kx7 matches them.
  function automatic logic [10:0] encode_lane(input logic [7:0] b, input logic k,
                                              input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       is_k28, is_kx7, a7, rd6;
    logic [5:0] s;
    logic [3:0] f;
    x      = b[4:0];
    y      = b[7:5];
    is_k28 = k && (x == 5'd28);
    is_kx7 = k && (y == 3'd7) &&
             ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
    s = is_k28 ? 6'b001111 : six_neg(x);
    if (x == 5'd7)                s = rd ? 6'b000111 : 6'b111000;
    else if ($countones(s) != 3)  s = rd ? ~s : s;
    rd6 = rd ^ ($countones(s) != 3);
    // A7 avoids a run of five equal bits across the 6b/4b boundary
    a7 = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
         ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    if (is_k28)                           f = rd6 ? k28_four(y) : ~k28_four(y);
    else if ((y == 3'd7) && (is_kx7 || a7)) f = rd6 ? 4'b1000 : 4'b0111;
    else if (y == 3'd3)                   f = rd6 ? 4'b0011 : 4'b1100;
    else begin
      f = four_neg(y);
      if ($countones(f) != 2) f = rd6 ? ~f : f;
    end
    return {rd6 ^ ($countones(f) != 2), s, f};
  endfunction

  logic [10*NUM_LANES-1:0] code_next;
  logic [NUM_LANES-1:0]    rd_next;
  logic [10:0]             enc;
  logic [7:0]              lane_byte;
  logic                    lane_k;
`ifdef ENCODE_K_CHECK_EN
  logic [NUM_LANES-1:0]    kerr_next;
`endif
  logic                    accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // rd_out doubles as the lane RD register: both change only on accept.
  always_comb begin
    code_next = '0;
    rd_next   = '0;
    enc       = '0;
    lane_byte = '0;
    lane_k    = 1'b0;
`ifdef ENCODE_K_CHECK_EN
    kerr_next = '0;
`endif
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_byte = in_data[8*i +: 8];
      lane_k    = in_k[i];
`ifdef ENCODE_K_CHECK_EN
      if (lane_k && !k_valid(lane_byte)) begin
        kerr_next[i] = 1'b1;
        lane_byte    = 8'hBC;
      end
`endif
      enc                  = encode_lane(lane_byte, lane_k, rd_out[i]);
      code_next[10*i +: 10] = enc[9:0];
      rd_next[i]           = enc[10];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      rd_out    <= {NUM_LANES{RD_INIT}};
`ifdef ENCODE_K_CHECK_EN
      k_err     <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_code  <= code_next;
      rd_out    <= rd_next;
`ifdef ENCODE_K_CHECK_EN
      k_err     <= kerr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
